// File: rtl/dlau_pkg.sv
// Shared DLAU definitions: sequencer state encoding, default geometry and fp16 constants.
package dlau_pkg;

  localparam int unsigned DLAU_WIDTH  = 16;
  localparam int unsigned DLAU_TILE   = 32;
  localparam int unsigned DLAU_ADDR_W = 5;
  localparam int unsigned DLAU_CNT_W  = 8;
  localparam int unsigned DLAU_TMR_W  = 16;
  localparam int unsigned DLAU_PERF_W = 32;

  localparam logic [15:0] FP16_ONE = 16'h3C00;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_FLUSH   = 3'd3,
    S_PCLR    = 3'd4,
    S_ACCUM   = 3'd5,
    S_PFINAL  = 3'd6,
    S_DONE    = 3'd7
  } state_e;

endpackage

// File: rtl/dlau_cycle_timer.sv
// Reloadable down-counter used to pace the COMPUTE and ACCUM waits; holds at zero.
module dlau_cycle_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/dlau_seq_ctrl.sv
// DLAU job sequencer: streams weight tiles into BRAM, paces TMMU flush and PSAU accumulate, captures the sum.
// Define DLAU_SEQ_CTRL_PERF_EN to add the perf_cycles busy-cycle counter output.
module dlau_seq_ctrl
  import dlau_pkg::*;
#(
  parameter int unsigned WIDTH          = DLAU_WIDTH,
  parameter int unsigned TILE           = DLAU_TILE,
  parameter int unsigned COMPUTE_CYCLES = 5,
  parameter int unsigned ACCUM_CYCLES   = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [DLAU_CNT_W-1:0]  num_tiles,
  input  logic                   wr_valid,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   wr_ready,
  output logic                   ram_enable,
  output logic [DLAU_ADDR_W-1:0] ram_addr,
  output logic [WIDTH-1:0]       input_data,
  output logic                   reset_tmmu,
  output logic                   reset_psau,
  output logic                   store_psau,
  input  logic [WIDTH-1:0]       psau_out,
  output logic [WIDTH-1:0]       result,
  output logic                   result_valid,
  output logic                   busy,
  output logic [DLAU_CNT_W-1:0]  tile_cnt
`ifdef DLAU_SEQ_CTRL_PERF_EN
  ,
  output logic [DLAU_PERF_W-1:0] perf_cycles
`endif
);

  state_e                 state_q, state_d;
  logic [DLAU_ADDR_W-1:0] idx_q, idx_d;
  logic [DLAU_CNT_W-1:0]  tile_cnt_q, tile_cnt_d;
  logic [DLAU_CNT_W-1:0]  num_tiles_q, num_tiles_d;

  logic                   wr_ready_q, wr_ready_d;
  logic                   ram_enable_q, ram_enable_d;
  logic [DLAU_ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [WIDTH-1:0]       input_data_q, input_data_d;
  logic                   reset_tmmu_q, reset_tmmu_d;
  logic                   reset_psau_q, reset_psau_d;
  logic                   store_psau_q, store_psau_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic                   result_valid_q, result_valid_d;
  logic                   busy_q, busy_d;

  logic                   tmr_load;
  logic [DLAU_TMR_W-1:0]  tmr_val;
  logic [DLAU_TMR_W-1:0]  tmr_count;

  dlau_cycle_timer #(
    .W (DLAU_TMR_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .count_o    (tmr_count)
  );

  // Next-state logic; every output register is loaded from the next state so it lines up with state_q.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    tile_cnt_d     = tile_cnt_q;
    num_tiles_d    = num_tiles_q;
    tmr_load       = 1'b0;
    tmr_val        = '0;
    ram_enable_d   = 1'b0;
    ram_addr_d     = ram_addr_q;
    input_data_d   = input_data_q;
    result_d       = result_q;
    result_valid_d = 1'b0;

    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      idx_d      = '0;
      tile_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            idx_d       = '0;
            tile_cnt_d  = '0;
            num_tiles_d = num_tiles;
            state_d     = (num_tiles == '0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          if (wr_valid && wr_ready_q) begin
            ram_enable_d = 1'b1;
            ram_addr_d   = idx_q;
            input_data_d = wr_data;
            if (idx_q == DLAU_ADDR_W'(TILE - 1)) begin
              idx_d    = '0;
              state_d  = S_COMPUTE;
              tmr_load = 1'b1;
              tmr_val  = DLAU_TMR_W'(COMPUTE_CYCLES - 1);
            end else begin
              idx_d = idx_q + DLAU_ADDR_W'(1);
            end
          end
        end
        S_COMPUTE: begin
          if (tmr_count == '0) begin
            state_d    = S_FLUSH;
            tile_cnt_d = tile_cnt_q + DLAU_CNT_W'(1);
          end
        end
        S_FLUSH: begin
          // tile_cnt_q already holds the incremented count here
          state_d = (tile_cnt_q < num_tiles_q) ? S_LOAD : S_PCLR;
        end
        S_PCLR: begin
          state_d  = S_ACCUM;
          tmr_load = 1'b1;
          tmr_val  = DLAU_TMR_W'(ACCUM_CYCLES - 1);
        end
        S_ACCUM: begin
          if (tmr_count == '0) begin
            state_d        = S_PFINAL;
            result_d       = psau_out;
            result_valid_d = 1'b1;
          end
        end
        S_PFINAL: state_d = S_DONE;
        S_DONE:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end

    wr_ready_d   = (state_d == S_LOAD);
    reset_tmmu_d = (state_d == S_FLUSH);
    reset_psau_d = (state_d == S_PCLR) || (state_d == S_PFINAL);
    store_psau_d = (state_d == S_ACCUM);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      tile_cnt_q     <= '0;
      num_tiles_q    <= '0;
      wr_ready_q     <= 1'b0;
      ram_enable_q   <= 1'b0;
      ram_addr_q     <= '0;
      input_data_q   <= '0;
      reset_tmmu_q   <= 1'b0;
      reset_psau_q   <= 1'b0;
      store_psau_q   <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      tile_cnt_q     <= tile_cnt_d;
      num_tiles_q    <= num_tiles_d;
      wr_ready_q     <= wr_ready_d;
      ram_enable_q   <= ram_enable_d;
      ram_addr_q     <= ram_addr_d;
      input_data_q   <= input_data_d;
      reset_tmmu_q   <= reset_tmmu_d;
      reset_psau_q   <= reset_psau_d;
      store_psau_q   <= store_psau_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign wr_ready     = wr_ready_q;
  assign ram_enable   = ram_enable_q;
  assign ram_addr     = ram_addr_q;
  assign input_data   = input_data_q;
  assign reset_tmmu   = reset_tmmu_q;
  assign reset_psau   = reset_psau_q;
  assign store_psau   = store_psau_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign tile_cnt     = tile_cnt_q;

`ifdef DLAU_SEQ_CTRL_PERF_EN
  logic [DLAU_PERF_W-1:0] perf_q, perf_d;

  // The accepting start cycle counts as the first cycle of the job.
  always_comb begin
    perf_d = perf_q;
    if ((state_q == S_IDLE) && start && !abort) begin
      perf_d = DLAU_PERF_W'(1);
    end else if ((state_q != S_IDLE) && (perf_q != '1)) begin
      perf_d = perf_q + DLAU_PERF_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_dlau_seq_ctrl.sv
// Scoreboard bench for dlau_seq_ctrl: expected output events are queued by the driver and popped by a monitor.
module tb_dlau_seq_ctrl;
  import dlau_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  num_tiles = 8'd0;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_data = 16'd0;
  logic        wr_ready;
  logic        ram_enable;
  logic [4:0]  ram_addr;
  logic [15:0] input_data;
  logic        reset_tmmu;
  logic        reset_psau;
  logic        store_psau;
  logic [15:0] psau_out = 16'd0;
  logic [15:0] result;
  logic        result_valid;
  logic        busy;
  logic [7:0]  tile_cnt;
`ifdef DLAU_SEQ_CTRL_PERF_EN
  logic [31:0] perf_cycles;
`endif

  dlau_seq_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .num_tiles    (num_tiles),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .ram_enable   (ram_enable),
    .ram_addr     (ram_addr),
    .input_data   (input_data),
    .reset_tmmu   (reset_tmmu),
    .reset_psau   (reset_psau),
    .store_psau   (store_psau),
    .psau_out     (psau_out),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .tile_cnt     (tile_cnt)
`ifdef DLAU_SEQ_CTRL_PERF_EN
    ,
    .perf_cycles  (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] val;
  } ev_t;

  localparam logic [2:0] K_WR    = 3'd0;
  localparam logic [2:0] K_TMMU  = 3'd1;
  localparam logic [2:0] K_PCLR  = 3'd2;
  localparam logic [2:0] K_STORE = 3'd3;
  localparam logic [2:0] K_RES   = 3'd4;

  ev_t exp_q[$];
  int  tests = 0;
  int  errors = 0;
  int  cyc = 0;
  int  last_hs = 0;
  int  tmmu_cyc = 0;
  int  n_wr = 0;
  int  n_tmmu = 0;
  int  n_res = 0;
  bit  overlap_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] kind, input logic [31:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  // Final phase of a job: PSAU clear, ACCUM stores, then the captured result with the closing clear.
  task automatic push_tail(input logic [15:0] sum);
    push(K_PCLR, 32'd0);
    for (int k = 0; k < 6; k++) push(K_STORE, 32'd0);
    push(K_RES, {15'd0, 1'b1, sum});
  endtask

  task automatic observe(input logic [2:0] kind, input logic [31:0] val);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: got unexpected kind %0d val %0h, expected no event", kind, val);
    end else begin
      e = exp_q.pop_front();
      if ((e.kind !== kind) || (e.val !== val)) begin
        errors++;
        $display("FAIL scoreboard: got kind %0d val %0h, expected kind %0d val %0h",
                 kind, val, e.kind, e.val);
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if ((32'(reset_tmmu) + 32'(reset_psau) + 32'(store_psau)) > 32'd1) overlap_seen = 1'b1;
      if (ram_enable) begin
        n_wr++;
        observe(K_WR, {11'd0, ram_addr, input_data});
      end
      if (reset_tmmu) begin
        n_tmmu++;
        tmmu_cyc = cyc;
        observe(K_TMMU, 32'd0);
      end
      if (reset_psau && !result_valid) observe(K_PCLR, 32'd0);
      if (store_psau) observe(K_STORE, 32'd0);
      if (result_valid) begin
        n_res++;
        observe(K_RES, {15'd0, reset_psau, result});
      end
    end
  end

  task automatic start_job(input logic [7:0] n);
    start = 1'b1;
    num_tiles = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offers n words; stall=1 drops wr_valid every other cycle. Expected writes are queued on handshake.
  task automatic load_words(input int n, input logic [15:0] base, input bit stall, input bit inc);
    int  i = 0;
    int  g = 0;
    bit  ph = 1'b0;
    while ((i < n) && (g < 1000)) begin
      wr_valid = !(stall && ph);
      wr_data  = inc ? (base + 16'(i)) : base;
      ph = !ph;
      if (wr_valid && wr_ready) begin
        push(K_WR, {11'd0, 5'(i % 32), wr_data});
        last_hs = cyc;
        i++;
      end
      @(posedge clk); #1;
      g++;
    end
    wr_valid = 1'b0;
    check("load_words_accepted", 32'(i), 32'(n));
  endtask

  task automatic wait_idle(input string name);
    int g = 0;
    while (busy && (g < 300)) begin
      @(posedge clk); #1;
      g++;
    end
    check({name, "_returns_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic run_one_tile(input string name, input logic [15:0] base, input bit inc,
                              input logic [15:0] sum);
    int w0, t0, r0;
    w0 = n_wr; t0 = n_tmmu; r0 = n_res;
    psau_out = sum;
    start_job(8'd1);
    load_words(32, base, 1'b0, inc);
    push(K_TMMU, 32'd0);
    push_tail(sum);
    wait_idle(name);
    check({name, "_tmmu_delay"}, 32'(tmmu_cyc - last_hs), 32'd6);
    check({name, "_writes"}, 32'(n_wr - w0), 32'd32);
    check({name, "_tmmu_pulses"}, 32'(n_tmmu - t0), 32'd1);
    check({name, "_results"}, 32'(n_res - r0), 32'd1);
    check({name, "_result"}, 32'(result), 32'(sum));
    check({name, "_tile_cnt"}, 32'(tile_cnt), 32'd1);
  endtask

  initial begin
    int w0, t0, r0, g;

    // Reset state, while reset is still asserted
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_outputs", {wr_ready, ram_enable, reset_tmmu, reset_psau, store_psau,
                            result_valid, ram_addr, tile_cnt}, 32'd0);
    check("reset_result", 32'(result), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // One tile of fp16 1.0 words, no stalls
    run_one_tile("one_tile", FP16_ONE, 1'b0, 16'h4A00);
`ifdef DLAU_SEQ_CTRL_PERF_EN
    check("perf_cycles", perf_cycles, 32'd48);
`endif

    // Two tiles with wr_valid dropped every other cycle
    w0 = n_wr; t0 = n_tmmu; r0 = n_res;
    psau_out = 16'h1234;
    start_job(8'd2);
    load_words(32, 16'h0100, 1'b1, 1'b1);
    push(K_TMMU, 32'd0);
    load_words(32, 16'h0200, 1'b1, 1'b1);
    push(K_TMMU, 32'd0);
    push_tail(16'h1234);
    wait_idle("two_tiles");
    check("two_tiles_writes", 32'(n_wr - w0), 32'd64);
    check("two_tiles_tmmu_pulses", 32'(n_tmmu - t0), 32'd2);
    check("two_tiles_tile_cnt", 32'(tile_cnt), 32'd2);
    check("two_tiles_result", 32'(result), 32'h1234);
    check("two_tiles_results", 32'(n_res - r0), 32'd1);

    // Zero-tile job: straight to DONE, no pulses, result holds
    w0 = n_wr; t0 = n_tmmu; r0 = n_res;
    start_job(8'd0);
    check("zero_done_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("zero_back_idle", 32'(busy), 32'd0);
    check("zero_tile_cnt", 32'(tile_cnt), 32'd0);
    check("zero_result_hold", 32'(result), 32'h1234);
    check("zero_no_activity", 32'((n_wr - w0) + (n_tmmu - t0) + (n_res - r0)), 32'd0);

    // start and abort together in IDLE: stay idle
    start = 1'b1; abort = 1'b1; num_tiles = 8'd1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(posedge clk); #1;
    check("start_abort_idle", 32'({busy, wr_ready}), 32'd0);

    // Abort during the third ACCUM cycle
    r0 = n_res;
    psau_out = 16'h5555;
    start_job(8'd1);
    load_words(32, 16'h0A00, 1'b0, 1'b1);
    push(K_TMMU, 32'd0);
    push(K_PCLR, 32'd0);
    for (int k = 0; k < 3; k++) push(K_STORE, 32'd0);
    g = 0;
    while (!store_psau && (g < 100)) begin
      @(posedge clk); #1;
      g++;
    end
    check("abort_accum_reached", 32'(store_psau), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_store_low", 32'(store_psau), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_tile_cnt", 32'(tile_cnt), 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    check("abort_no_result", 32'(n_res - r0), 32'd0);
    check("abort_result_hold", 32'(result), 32'h1234);

    // New job after abort runs normally
    run_one_tile("after_abort", 16'h7000, 1'b1, 16'hBEEF);

    // Asynchronous reset while loading word 10
    start_job(8'd1);
    load_words(10, 16'h2000, 1'b0, 1'b1);
    @(negedge clk); #1;
    check("pre_reset_addr", 32'(ram_addr), 32'd9);
    reset = 1'b1;
    #1;
    check("async_reset_busy", 32'(busy), 32'd0);
    check("async_reset_ctrl", 32'({wr_ready, ram_enable, reset_tmmu, reset_psau, store_psau,
                                   result_valid}), 32'd0);
    check("async_reset_addr", 32'(ram_addr), 32'd0);
    check("async_reset_data", 32'(input_data), 32'd0);
    check("async_reset_result", 32'(result), 32'd0);
    check("async_reset_tile_cnt", 32'(tile_cnt), 32'd0);
    @(posedge clk); #3;
    reset = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("post_reset_no_restart", 32'(busy), 32'd0);

    // Restart writes from address 0
    run_one_tile("restart", 16'h3000, 1'b1, 16'h0F0F);

    repeat (3) begin @(posedge clk); #1; end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("pulse_exclusive", 32'(overlap_seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
